param_tick_counter: RTL and testbench
=====================================

PARAM_TICK_COUNTER -- requirements
Module: param_tick_counter

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, tick rate in Hz; DIV = CLK_HZ/TICK_HZ (integer), DIV >= 2 required, elaboration error otherwise.
REQ-003 Parameter WIDTH, default 8, count width in bits.
REQ-004 Parameter MAX_COUNT, default 2**WIDTH-1, terminal value; MAX_COUNT <= 2**WIDTH-1, >= 1.
REQ-005 Parameter SATURATE, default 0; 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-006 CLK100MHZ  input  1  sole clock, all state updates on rising edge.
REQ-007 RST  input  1  synchronous, active-high reset.
REQ-008 en  input  1  1 = prescaler runs; 0 = prescaler and count frozen.
REQ-009 up_down  input  1  1 = count up on tick, 0 = count down.
REQ-010 clear  input  1  synchronous clear of prescaler and count.
REQ-011 load  input  1  synchronous load of count from load_val.
REQ-012 load_val  input  WIDTH  value loaded when load=1.
REQ-013 count  output  WIDTH  registered counter value.
REQ-014 tick  output  1  registered one-cycle strobe at TICK_HZ.
REQ-015 tick_clk  output  1  registered square wave at TICK_HZ.
REQ-016 tc  output  1  registered one-cycle terminal-count strobe.

Function
REQ-017 Prescaler ps counts 0..DIV-1 on each edge with en=1; at ps==DIV-1 it returns to 0.
REQ-018 tick SHALL be 1 for exactly the cycle following the edge on which ps went DIV-1 -> 0; 0 otherwise.
REQ-019 count SHALL update on the same edge that sets tick, so the new count is visible during the tick=1 cycle.
REQ-020 tick_clk SHALL be registered: 0 while ps < DIV/2 (integer division), 1 while ps >= DIV/2; odd DIV gives the extra cycle to the high phase.
REQ-021 Up tick: count < MAX_COUNT -> count+1; count == MAX_COUNT -> 0 (SATURATE=0) or hold MAX_COUNT (SATURATE=1).
REQ-022 Down tick: count > 0 -> count-1; count == 0 -> MAX_COUNT (SATURATE=0) or hold 0 (SATURATE=1).
REQ-023 tc SHALL pulse 1 in the same cycle as tick when that tick met a boundary (up at MAX_COUNT, down at 0), in both SATURATE modes.
REQ-024 Priority per edge: RST > clear > load > tick.
REQ-025 clear=1: ps <= 0, count <= 0, tick <= 0, tc <= 0, tick_clk <= 0; en is ignored.
REQ-026 load=1 (clear=0): count <= min(load_val, MAX_COUNT), tick <= 0, tc <= 0; ps advances normally; any tick due on this edge is dropped.
REQ-027 en=0: ps, count and tick_clk hold; tick and tc are 0.
REQ-028 up_down is sampled only on the tick edge; changing it mid-period has no other effect.
REQ-029 The count value SHALL never exceed MAX_COUNT under any input sequence.

Reset
REQ-030 RST=1 on an edge: ps <= 0, count <= 0, tick <= 0, tc <= 0, tick_clk <= 0; all other inputs are ignored.
REQ-031 RST asserted mid-period discards partial prescaler progress; the first tick after release occurs DIV edges with en=1 after the release edge.

Verification (CLK_HZ=10, TICK_HZ=1, so DIV=10; WIDTH=4, MAX_COUNT=9 unless stated)
REQ-032 Reset, then en=1 and up_down=1 for 30 cycles -> tick high on cycles 10, 20, 30 after release; count 1, 2, 3; tick_clk low for 5 cycles, then high for 5.
REQ-033 SATURATE=0, load_val=9, up tick -> count=0 and tc=1 for one cycle; down tick from 0 -> count=9 and tc=1.
REQ-034 SATURATE=1, count=9, up tick -> count stays 9 and tc=1; count=0, down tick -> count stays 0 and tc=1.
REQ-035 load=1 with load_val=15 on the tick edge -> count=9, tick=0, tc=0; the next tick occurs 10 cycles later.
REQ-036 clear and load both asserted together with ps=7 -> count=0, ps=0; the next tick occurs 10 en cycles later.
REQ-037 en=0 for 25 cycles mid-period (ps=4) -> no tick, count and tick_clk held; the tick occurs 6 en cycles after en returns to 1.

Source files
------------

// File: rtl/param_tick_counter.sv
// param_tick_counter: prescaled up/down counter with tick strobe, tick
// square wave and terminal-count strobe. Prescaler divides CLK_HZ down to
// TICK_HZ; each prescaler wrap advances the count by one.
module param_tick_counter #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             en,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tick_clk,
  output logic             tc
);

  localparam int unsigned DIV  = (TICK_HZ == 0) ? 0 : CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HALF = DIV / 2;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(DIV - 1);
  localparam logic [PS_W-1:0]  PS_HALF = PS_W'(HALF);
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);

  // Elaboration-time parameter legality checks
  if (DIV < 2) begin : g_bad_div
    $error("param_tick_counter: CLK_HZ/TICK_HZ must be >= 2");
  end
  if (MAX_COUNT < 1) begin : g_bad_max_lo
    $error("param_tick_counter: MAX_COUNT must be >= 1");
  end
  if (WIDTH < 32 && MAX_COUNT > (2**WIDTH - 1)) begin : g_bad_max_hi
    $error("param_tick_counter: MAX_COUNT does not fit in WIDTH bits");
  end

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             tick_clk_q, tick_clk_d;

  logic             ps_wrap;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_step;
  logic             at_boundary;

  // Count value a tick would produce, and whether that tick hits a boundary
  always_comb begin
    count_step  = count_q;
    at_boundary = 1'b0;
    if (up_down) begin
      if (count_q >= MAX_C) begin
        at_boundary = 1'b1;
        count_step  = SATURATE ? MAX_C : '0;
      end else begin
        count_step  = count_q + WIDTH'(1);
      end
    end else begin
      if (count_q == '0) begin
        at_boundary = 1'b1;
        count_step  = SATURATE ? '0 : MAX_C;
      end else begin
        count_step  = count_q - WIDTH'(1);
      end
    end
  end

  // Next-state: clear > load > tick; RST is applied in the register block
  always_comb begin
    ps_d         = ps_q;
    count_d      = count_q;
    tick_d       = 1'b0;
    tc_d         = 1'b0;
    ps_wrap      = (ps_q == PS_LAST);
    load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

    if (clear) begin
      ps_d    = '0;
      count_d = '0;
    end else begin
      if (en) begin
        ps_d = ps_wrap ? '0 : ps_q + PS_W'(1);
      end
      if (load) begin
        // A tick falling on a load edge is dropped
        count_d = load_clamped;
      end else if (en && ps_wrap) begin
        tick_d  = 1'b1;
        count_d = count_step;
        tc_d    = at_boundary;
      end
    end

    // Square wave tracks the registered prescaler phase; odd DIV favours high
    tick_clk_d = (ps_d >= PS_HALF);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      ps_q       <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      tc_q       <= 1'b0;
      tick_clk_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      tc_q       <= tc_d;
      tick_clk_q <= tick_clk_d;
    end
  end

  assign count    = count_q;
  assign tick     = tick_q;
  assign tick_clk = tick_clk_q;
  assign tc       = tc_q;

endmodule

// File: tb/tb_param_tick_counter.sv
// Directed bench for param_tick_counter: DIV=10, WIDTH=4, MAX_COUNT=9.
// Two instances share stimulus: u_wrap (SATURATE=0) and u_sat (SATURATE=1).
module tb_param_tick_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_down = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count0, count1;
  logic       tick0, tick1, tclk0, tclk1, tc0, tc1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  param_tick_counter #(
    .CLK_HZ(10), .TICK_HZ(1), .WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)
  ) u_wrap (
    .CLK100MHZ(clk), .RST(rst), .en(en), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val), .count(count0), .tick(tick0),
    .tick_clk(tclk0), .tc(tc0)
  );

  param_tick_counter #(
    .CLK_HZ(10), .TICK_HZ(1), .WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)
  ) u_sat (
    .CLK100MHZ(clk), .RST(rst), .en(en), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val), .count(count1), .tick(tick1),
    .tick_clk(tclk1), .tc(tc1)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] e_cnt0;
    logic [3:0] e_cnt1;
    logic       e_tclk;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expects ps==0 on entry; runs a full period with up_down flipped until the
  // tick edge, then checks the tick cycle
  task automatic run_to_tick(input logic dir, input logic [3:0] e0, input logic [3:0] e1,
                             input logic etc0, input logic etc1);
    for (int i = 1; i <= 10; i++) begin
      en      = 1'b1;
      up_down = (i == 10) ? dir : ~dir;
      cyc();
      if (i < 10) begin
        chk("idle_tick0", 32'(tick0), 0);
        chk("idle_tick1", 32'(tick1), 0);
        chk("idle_tclk", 32'(tclk0), (i >= 5) ? 1 : 0);
      end else begin
        chk("tick0", 32'(tick0), 1);
        chk("tick1", 32'(tick1), 1);
        chk("tick_cnt0", 32'(count0), 32'(e0));
        chk("tick_cnt1", 32'(count1), 32'(e1));
        chk("tick_tc0", 32'(tc0), 32'(etc0));
        chk("tick_tc1", 32'(tc1), 32'(etc1));
        chk("tick_tclk", 32'(tclk0), 0);
      end
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      cyc();
      chk("run_tick", 32'(tick0), 0);
    end
  endtask

  initial begin
    vec_t tbl[10];
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 4'd9, 4'd9, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4,  4'd4, 4'd4, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 4'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7,  4'd0, 4'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5,  4'd0, 4'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  4'd9, 4'd9, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 4'd9, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 4'd9, 4'd9, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 4'd9, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 4'd0, 1'b0};

    // Reset state
    cyc();
    chk("rst_cnt0", 32'(count0), 0);
    chk("rst_cnt1", 32'(count1), 0);
    chk("rst_tick", 32'(tick0), 0);
    chk("rst_tclk", 32'(tclk0), 0);
    chk("rst_tc", 32'(tc0), 0);

    // Free-running up count: ticks every 10 cycles, 5 low / 5 high tick_clk
    rst = 1'b0; en = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      chk("run_tick", 32'(tick0), (i % 10 == 0) ? 1 : 0);
      chk("run_cnt", 32'(count0), 32'(i / 10));
      chk("run_tclk", 32'(tclk1), ((i % 10) >= 5) ? 1 : 0);
      chk("run_tc", 32'(tc0), 0);
    end

    // Single-cycle priority vectors (ps starts at 0, count at 3)
    for (int v = 0; v < 10; v++) begin
      rst = tbl[v].rst; en = tbl[v].en; up_down = tbl[v].up;
      clear = tbl[v].clr; load = tbl[v].ld; load_val = tbl[v].lv;
      cyc();
      chk("vec_cnt0", 32'(count0), 32'(tbl[v].e_cnt0));
      chk("vec_cnt1", 32'(count1), 32'(tbl[v].e_cnt1));
      chk("vec_tclk", 32'(tclk0), 32'(tbl[v].e_tclk));
      chk("vec_tick", 32'(tick0 | tick1), 0);
      chk("vec_tc", 32'(tc0 | tc1), 0);
    end
    rst = 1'b0; clear = 1'b0; load = 1'b0;

    // Up tick at MAX_COUNT: wrap to 0 vs hold 9, both strobe tc
    en = 1'b0; load = 1'b1; load_val = 4'd9; cyc(); load = 1'b0;
    run_to_tick(1'b1, 4'd0, 4'd9, 1'b1, 1'b1);
    en = 1'b0; load = 1'b1; load_val = 4'd0; cyc(); load = 1'b0;
    chk("tc_one_cycle", 32'(tc0 | tc1), 0);
    chk("tick_one_cycle", 32'(tick0 | tick1), 0);
    // Down tick at 0: wrap to 9 vs hold 0
    run_to_tick(1'b0, 4'd9, 4'd0, 1'b1, 1'b1);
    // Non-boundary down on the wrapping instance only
    run_to_tick(1'b0, 4'd8, 4'd0, 1'b0, 1'b1);

    // Load on the tick edge drops the tick and clamps to MAX_COUNT
    run_n(9);
    load = 1'b1; load_val = 4'd15; up_down = 1'b1; cyc(); load = 1'b0;
    chk("ldtick_cnt0", 32'(count0), 9);
    chk("ldtick_cnt1", 32'(count1), 9);
    chk("ldtick_tick", 32'(tick0), 0);
    chk("ldtick_tc", 32'(tc0), 0);
    run_to_tick(1'b1, 4'd0, 4'd9, 1'b1, 1'b1);

    // Clear with load at ps=7 restarts the period
    run_n(7);
    chk("ps7_tclk", 32'(tclk0), 1);
    clear = 1'b1; load = 1'b1; load_val = 4'd5; cyc(); clear = 1'b0; load = 1'b0;
    chk("clrld_cnt0", 32'(count0), 0);
    chk("clrld_cnt1", 32'(count1), 0);
    chk("clrld_tclk", 32'(tclk0), 0);
    run_to_tick(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);

    // en=0 for 25 cycles at ps=4 freezes everything
    run_n(4);
    en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      chk("frz_tick", 32'(tick0), 0);
      chk("frz_cnt", 32'(count0), 1);
      chk("frz_tclk", 32'(tclk0), 0);
    end
    run_n(5);
    en = 1'b1; cyc();
    chk("unfrz_tick", 32'(tick0), 1);
    chk("unfrz_cnt", 32'(count1), 2);

    // Reset mid-period discards partial progress
    run_n(3);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_cnt", 32'(count0), 0);
    run_to_tick(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
